// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with scan-code FIFO
// Frame decode runs on synchronised PS2C falling edges; good codes are queued.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          PS2C,
  input  logic                          PS2D,
  input  logic                          RD,
  output logic [7:0]                    DATA,
  output logic                          VALID,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          FRAME_ERR,
  output logic                          OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA_BITS, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] c_sync, d_sync;
  logic                   c_prev;
  logic                   fall, d_s;

  state_t                 st;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TW-1:0]          idle_cnt;

  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   good, pop, push_ok;

  // Presetting to the idle-high level keeps reset from looking like a falling edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      c_sync <= '1;
      d_sync <= '1;
      c_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], PS2C};
      d_sync <= {d_sync[SYNC_STAGES-2:0], PS2D};
      c_prev <= c_sync[SYNC_STAGES-1];
    end
  end

  assign fall = c_prev & ~c_sync[SYNC_STAGES-1];
  assign d_s  = d_sync[SYNC_STAGES-1];

  assign good    = (st == STOP) && fall && d_s && ((^shreg) ^ par_bit);
  assign pop     = RD && (COUNT != '0);
  assign push_ok = good && ((COUNT != FULL) || pop);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st        <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      idle_cnt  <= '0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= 1'b0;
      if (st == IDLE) begin
        idle_cnt <= '0;
        if (fall && !d_s) begin
          st      <= DATA_BITS;
          bit_cnt <= '0;
          shreg   <= '0;
        end
      end else if (idle_cnt == TLIM) begin
        st        <= IDLE;
        idle_cnt  <= '0;
        FRAME_ERR <= 1'b1;
      end else if (fall) begin
        idle_cnt <= '0;
        case (st)
          DATA_BITS: begin
            shreg[bit_cnt] <= d_s;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) st <= PARITY;
          end
          PARITY: begin
            par_bit <= d_s;
            st      <= STOP;
          end
          default: begin
            st        <= IDLE;
            FRAME_ERR <= !good;
          end
        endcase
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

  // A full FIFO still accepts a push when the same cycle pops.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      COUNT    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (good && !push_ok) OVERFLOW <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      COUNT <= COUNT + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  assign VALID = (COUNT != '0);
  assign DATA  = VALID ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  localparam int TO = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [3:0] count;
  logic       frame_err;
  logic       overflow;

  int n_checks = 0;
  int n_fail = 0;
  int err_pulses = 0;
  int err_cycles = 0;
  logic err_prev = 1'b0;

  ps2_rx_fifo #(.FIFO_DEPTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RST_N(rst_n), .PS2C(ps2c), .PS2D(ps2d), .RD(rd),
    .DATA(data), .VALID(valid), .COUNT(count),
    .FRAME_ERR(frame_err), .OVERFLOW(overflow)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) err_cycles++;
    if (frame_err && !err_prev) err_pulses++;
    err_prev = frame_err;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic par_ok);
    logic p;
    p = ~^d;
    if (!par_ok) p = ~p;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2d = bits[i];
      cyc(10);
      ps2c = 1'b0;
      cyc(20);
      ps2c = 1'b1;
      cyc(10);
    end
  endtask

  task automatic send(input logic [7:0] d);
    send_bits(frame(d, 1'b1), 0, 10);
  endtask

  // Stop bit timed so RD lands exactly on the push cycle.
  task automatic send_with_rd(input logic [7:0] d);
    send_bits(frame(d, 1'b1), 0, 9);
    ps2d = 1'b1;
    cyc(10);
    ps2c = 1'b0;
    cyc(2);
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    cyc(17);
    ps2c = 1'b1;
    cyc(10);
  endtask

  task automatic pop_one;
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    cyc(1);
  endtask

  initial begin
    cyc(3);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    cyc(5);

    send(8'h1C);
    chk("f1c_valid", valid, 1);
    chk("f1c_data", data, 8'h1C);
    chk("f1c_count", count, 1);
    chk("f1c_noerr", err_pulses, 0);
    pop_one();
    chk("pop_valid", valid, 0);
    chk("pop_data", data, 8'h00);
    chk("pop_count", count, 0);

    send_bits(frame(8'hF0, 1'b0), 0, 10);
    chk("par_pulses", err_pulses, 1);
    chk("par_cycles", err_cycles, 1);
    chk("par_count", count, 0);
    send(8'h1C);
    chk("after_par_data", data, 8'h1C);
    chk("after_par_count", count, 1);
    pop_one();

    send_bits(frame(8'hAA, 1'b1), 0, 4);
    cyc(TO + 10);
    chk("to_pulses", err_pulses, 2);
    chk("to_cycles", err_cycles, 2);
    chk("to_count", count, 0);
    send(8'h15);
    chk("after_to_data", data, 8'h15);
    chk("after_to_count", count, 1);
    pop_one();
    chk("after_to_empty", count, 0);

    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("fill_count", count, 8);
    chk("fill_ovf", overflow, 0);
    send(8'h09);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_pop%0d", i), data, 32'(i));
      pop_one();
    end
    chk("ovf_empty", valid, 0);
    chk("ovf_sticky", overflow, 1);

    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk("rst2_ovf", overflow, 0);
    for (int i = 1; i <= 8; i++) send(8'(i));
    send_with_rd(8'h09);
    chk("rdpush_count", count, 8);
    chk("rdpush_ovf", overflow, 0);
    for (int i = 2; i <= 9; i++) begin
      chk($sformatf("rdpush_pop%0d", i), data, 32'(i));
      pop_one();
    end
    chk("rdpush_empty", count, 0);

    send(8'h22);
    send_bits(frame(8'h1C, 1'b1), 0, 3);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("mid_data", data, 8'h00);
    chk("mid_valid", valid, 0);
    chk("mid_count", count, 0);
    chk("mid_ferr", frame_err, 0);
    send_bits(frame(8'h1C, 1'b1), 4, 10);
    chk("mid_nopush", count, 0);
    cyc(TO + 20);
    send(8'h1C);
    chk("mid_next_data", data, 8'h1C);
    chk("mid_next_count", count, 1);
    pop_one();

    ps2d = 1'b1;
    cyc(5);
    ps2c = 1'b0;
    cyc(3);
    ps2c = 1'b1;
    cyc(TO + 20);
    chk("glitch_pulses", err_pulses, 3);
    chk("glitch_cycles", err_cycles, 3);
    chk("glitch_count", count, 0);
    send(8'h5A);
    chk("glitch_next_data", data, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
